// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing generator with four selectable test patterns.
// All outputs are registered; outputs in cycle n+1 describe the (hc, vc) held in cycle n.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned COLOR_BITS = 4,
    parameter int unsigned CHECK_LOG2 = 5,
    parameter int unsigned BOX        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b,
    output logic                  hs,
    output logic                  vs,
    output logic                  de,
    output logic                  frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BW      = $clog2(BAR_W + 1);

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic [BW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    mode_q, cur_mode;
    logic [7:0]    fc_q;
    logic [HW-1:0] bx_q, bx_d;
    logic [VW-1:0] by_q, by_d;
    logic          dx_q, dx_d, dy_q, dy_d;

    logic line_end, at_origin, active, hs_on, vs_on, in_box, chk;
    logic [COLOR_BITS-1:0] pix_r, pix_g, pix_b;

    always_comb begin
        line_end  = (hc_q == HW'(H_TOTAL - 1));
        at_origin = (hc_q == '0) && (vc_q == '0);
        // The new mode already applies to pixel (0,0), so the switch lands on frame_start.
        cur_mode  = at_origin ? mode : mode_q;

        hc_d = line_end ? '0 : hc_q + 1'b1;
        vc_d = vc_q;
        if (line_end) begin
            vc_d = (vc_q == VW'(V_TOTAL - 1)) ? '0 : vc_q + 1'b1;
        end

        bar_pix_d = bar_pix_q + 1'b1;
        bar_idx_d = bar_idx_q;
        if (line_end) begin
            bar_pix_d = '0;
            bar_idx_d = '0;
        end else if (bar_pix_q == BW'(BAR_W - 1)) begin
            bar_pix_d = '0;
            bar_idx_d = bar_idx_q + 1'b1;
        end

        active = (32'(hc_q) < H_ACTIVE) && (32'(vc_q) < V_ACTIVE);
        hs_on  = (32'(hc_q) >= H_ACTIVE + H_FP) && (32'(hc_q) < H_ACTIVE + H_FP + H_SYNC);
        vs_on  = (32'(vc_q) >= V_ACTIVE + V_FP) && (32'(vc_q) < V_ACTIVE + V_FP + V_SYNC);
        in_box = (32'(hc_q) >= 32'(bx_q)) && (32'(hc_q) < 32'(bx_q) + BOX) &&
                 (32'(vc_q) >= 32'(by_q)) && (32'(vc_q) < 32'(by_q) + BOX);
        chk    = 1'((32'(hc_q) ^ 32'(vc_q)) >> CHECK_LOG2);

        unique case (cur_mode)
            2'd0: begin
                pix_r = {COLOR_BITS{~bar_idx_q[1]}};
                pix_g = {COLOR_BITS{~bar_idx_q[2]}};
                pix_b = {COLOR_BITS{~bar_idx_q[0]}};
            end
            2'd1: begin
                pix_r = {COLOR_BITS{chk}};
                pix_g = {COLOR_BITS{chk}};
                pix_b = {COLOR_BITS{chk}};
            end
            2'd2: begin
                pix_r = COLOR_BITS'(32'(hc_q) >> 4);
                pix_g = COLOR_BITS'(32'(vc_q) >> 4);
                pix_b = COLOR_BITS'(fc_q >> (8 - COLOR_BITS));
            end
            default: begin
                pix_r = {COLOR_BITS{in_box}};
                pix_g = {COLOR_BITS{in_box}};
                pix_b = {COLOR_BITS{in_box}};
            end
        endcase

        // Box moves once per frame, on the first blanking line.
        bx_d = bx_q;
        by_d = by_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if ((hc_q == '0) && (32'(vc_q) == V_ACTIVE)) begin
            if (dx_q && (bx_q == HW'(H_ACTIVE - BOX))) begin
                dx_d = 1'b0;
                bx_d = bx_q - 1'b1;
            end else if (!dx_q && (bx_q == '0)) begin
                dx_d = 1'b1;
                bx_d = bx_q + 1'b1;
            end else begin
                bx_d = dx_q ? bx_q + 1'b1 : bx_q - 1'b1;
            end
            if (dy_q && (by_q == VW'(V_ACTIVE - BOX))) begin
                dy_d = 1'b0;
                by_d = by_q - 1'b1;
            end else if (!dy_q && (by_q == '0)) begin
                dy_d = 1'b1;
                by_d = by_q + 1'b1;
            end else begin
                by_d = dy_q ? by_q + 1'b1 : by_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q        <= '0;
            vc_q        <= '0;
            bar_pix_q   <= '0;
            bar_idx_q   <= '0;
            mode_q      <= '0;
            fc_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            bar_pix_q   <= bar_pix_d;
            bar_idx_q   <= bar_idx_d;
            mode_q      <= cur_mode;
            fc_q        <= at_origin ? fc_q + 8'd1 : fc_q;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            r           <= active ? pix_r : '0;
            g           <= active ? pix_g : '0;
            b           <= active ? pix_b : '0;
            de          <= active;
            frame_start <= at_origin;
            hs          <= hs_on ? HS_POL : ~HS_POL;
            vs          <= vs_on ? VS_POL : ~VS_POL;
        end
    end

endmodule
